vector_instruction_sequencer: RTL and testbench
===============================================

# vector_instruction_sequencer

Instruction-issue stage directly upstream of the vector processor. Buffers 9-bit vector instructions from a host in a small FIFO, then presents them one at a time on the processor's `opcode`, `regAddress` and `memoryAddress` inputs. Each instruction is held for an opcode-dependent number of cycles, so ADD/MUL register-file round-trips and LOAD/STORE memory transfers complete before the next instruction is presented. Also reports occupancy and a retired-instruction count.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, 2..16.
- `ALU_CYCLES`, 2: hold cycles for ADD (0) and MUL (1); ≥1.
- `MEM_CYCLES`, 1: hold cycles for LOAD (2) and STORE (3); ≥1.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  host offers `in_instr`.
- `in_instr`  in  9  {opcode[8:7], regAddress[6:5], memoryAddress[4:0]}.
- `in_ready`  out  1  FIFO can accept a write this cycle.
- `run`  in  1  issue enable; 0 blocks new pops only.
- `opcode`  out  2  to processor.
- `regAddress`  out  2  to processor.
- `memoryAddress`  out  5  to processor.
- `issue_valid`  out  1  high while an instruction is being held; the processor side must gate execution on it.
- `retire`  out  1  one-cycle pulse on the last hold cycle of each instruction.
- `busy`  out  1  `issue_valid` OR FIFO non-empty.
- `fifo_count`  out  5  current FIFO occupancy, 0..DEPTH.
- `retired_count`  out  8  retired instructions, modulo 256.

## Operation
- FIFO:
  - Circular buffer with read and write pointers that wrap modulo DEPTH, plus an occupancy counter.
  - Push occurs when `in_valid && in_ready`.
  - `in_ready = (fifo_count < DEPTH)`, evaluated from the registered count. A push is refused when the FIFO is full, even if a pop happens in the same cycle.
  - A simultaneous push and pop leaves `fifo_count` unchanged.
- FSM states: IDLE and EXEC. A hold counter `hold_cnt` counts down the remaining cycles.
- IDLE:
  - If `run && fifo_count > 0`: pop the head entry into the output registers, set `issue_valid = 1`, load `hold_cnt` with N−1, and go to EXEC.
  - N = ALU_CYCLES when popped opcode[1] = 0; N = MEM_CYCLES when opcode[1] = 1.
- EXEC while `hold_cnt != 0`: decrement `hold_cnt`; outputs are held.
- EXEC when `hold_cnt == 0` (last cycle):
  - `retire` = 1 combinationally and `retired_count` increments at the clock edge (wraps 255→0).
  - If `run && fifo_count > 0`: pop the next entry back-to-back with no bubble and stay in EXEC with `hold_cnt` = N−1 for the new opcode.
  - Otherwise go to IDLE and clear `issue_valid`.
- IDLE outputs:
  - `opcode`, `regAddress` and `memoryAddress` keep the last issued values.
  - `issue_valid` = 0 and `retire` = 0.
- `run` deasserted during EXEC: the current instruction completes and retires; no new pop follows.
- FIFO-empty pop attempts cannot occur, because the pop condition always includes `fifo_count > 0`.

## Timing
- Reset values (all registers clear synchronously when `rst` is high at a posedge):
  - `opcode`, `regAddress`, `memoryAddress`, `issue_valid`, `retire`, `retired_count`, `fifo_count`, both pointers: 0.
  - State = IDLE, so `busy` = 0 and `in_ready` = 1.
- Reset mid-operation:
  - The in-flight instruction is abandoned and not retired.
  - FIFO contents are discarded.
  - A push presented in the reset cycle is dropped.
- Push-to-issue latency:
  - Instruction written at edge k, FIFO previously empty, in IDLE with `run` = 1.
  - `fifo_count` = 1 after edge k.
  - Pop at edge k+1; `issue_valid` and the outputs are valid after k+1.
- Hold length: the outputs are stable for exactly N consecutive cycles, and `retire` is high in the Nth.
- Throughput: one instruction per N cycles while the FIFO is non-empty and `run` = 1.
- `fifo_count`, `in_ready` and `busy` are derived from registered state; there are no combinational paths from `in_valid` to `in_ready`.

## Test plan
- Reset, then single LOAD: push 9'b10_01_00101 with `run` = 1.
  - Required: one cycle later `opcode` = 2, `regAddress` = 1, `memoryAddress` = 5, `issue_valid` = 1.
  - `retire` pulses in that same cycle (MEM_CYCLES = 1).
  - `retired_count` = 1; `busy` = 0 afterwards.
- Back-to-back ADD r0 then MUL r1 with defaults:
  - ADD is held 2 cycles, then MUL is held 2 cycles with no IDLE gap.
  - `retire` is high in cycles 2 and 4; `retired_count` = 2.
- Fill with `run` = 0: push 9 instructions.
  - Required: `in_ready` drops after the 8th; the 9th is refused; `fifo_count` = 8.
  - After `run` = 1, 8 retires occur in program order.
- `run` dropped mid-EXEC of a MUL:
  - MUL completes and retires; no further pop; `issue_valid` = 0; `fifo_count` is unchanged.
- `rst` asserted in cycle 1 of a 2-cycle ADD with 3 entries queued:
  - Next cycle: all outputs 0, `fifo_count` = 0, no `retire`.
- 256 STOREs streamed through:
  - `retired_count` wraps to 0; the write pointer wraps at least 32 times with no loss or reordering (checked via the `memoryAddress` sequence).

Source files
------------

// File: rtl/vector_instruction_sequencer.sv
// vector_instruction_sequencer
// Buffers 9-bit vector instructions in a circular FIFO and issues them one at
// a time to the vector processor. Each instruction is held for ALU_CYCLES
// (ADD/MUL) or MEM_CYCLES (LOAD/STORE) cycles. The next instruction is popped
// back-to-back on the last hold cycle when issue is enabled.
module vector_instruction_sequencer #(
    parameter int DEPTH      = 8,
    parameter int ALU_CYCLES = 2,
    parameter int MEM_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [8:0] in_instr,
    output logic       in_ready,
    input  logic       run,
    output logic [1:0] opcode,
    output logic [1:0] regAddress,
    output logic [4:0] memoryAddress,
    output logic       issue_valid,
    output logic       retire,
    output logic       busy,
    output logic [4:0] fifo_count,
    output logic [7:0] retired_count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int MAX_CYC = (ALU_CYCLES > MEM_CYCLES) ? ALU_CYCLES : MEM_CYCLES;
    localparam int HOLD_W  = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [HOLD_W-1:0] ALU_HOLD  = HOLD_W'(ALU_CYCLES - 1);
    localparam logic [HOLD_W-1:0] MEM_HOLD  = HOLD_W'(MEM_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [4:0]        DEPTH_C   = 5'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t            state_r;
    logic [8:0]        mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [HOLD_W-1:0] hold_cnt_r;

    logic              push_s;
    logic              pop_s;
    logic [8:0]        head_s;
    logic [HOLD_W-1:0] hold_load_s;

    // Status flags come only from registered state, so in_valid never reaches in_ready.
    assign in_ready = (fifo_count < DEPTH_C);
    assign busy     = issue_valid || (fifo_count != 5'd0);
    assign retire   = (state_r == EXEC) && (hold_cnt_r == HOLD_ZERO);

    // Push/pop decisions and the hold length of the FIFO head.
    always_comb begin
        push_s      = in_valid && in_ready;
        head_s      = mem_r[rd_ptr_r];
        hold_load_s = ALU_HOLD;
        pop_s       = 1'b0;
        if (head_s[8]) begin
            hold_load_s = MEM_HOLD;
        end else begin
            hold_load_s = ALU_HOLD;
        end
        if (run && (fifo_count != 5'd0) &&
            ((state_r == IDLE) || (hold_cnt_r == HOLD_ZERO))) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= in_instr;
        end
    end

    // FIFO pointers (wrap naturally, DEPTH is a power of two) and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            fifo_count <= 5'd0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   fifo_count <= fifo_count + 5'd1;
                2'b01:   fifo_count <= fifo_count - 5'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Issue FSM: loads the head into the output registers and counts down its hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            hold_cnt_r    <= HOLD_ZERO;
            opcode        <= 2'd0;
            regAddress    <= 2'd0;
            memoryAddress <= 5'd0;
            issue_valid   <= 1'b0;
            retired_count <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pop_s) begin
                        opcode        <= head_s[8:7];
                        regAddress    <= head_s[6:5];
                        memoryAddress <= head_s[4:0];
                        hold_cnt_r    <= hold_load_s;
                        issue_valid   <= 1'b1;
                        state_r       <= EXEC;
                    end
                end
                EXEC: begin
                    if (hold_cnt_r != HOLD_ZERO) begin
                        hold_cnt_r <= hold_cnt_r - HOLD_ONE;
                    end else begin
                        retired_count <= retired_count + 8'd1;
                        if (pop_s) begin
                            opcode        <= head_s[8:7];
                            regAddress    <= head_s[6:5];
                            memoryAddress <= head_s[4:0];
                            hold_cnt_r    <= hold_load_s;
                        end else begin
                            issue_valid <= 1'b0;
                            state_r     <= IDLE;
                        end
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    issue_valid <= 1'b0;
                    hold_cnt_r  <= HOLD_ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_instruction_sequencer.sv
// Self-checking bench for vector_instruction_sequencer: directed scenarios plus
// randomized traffic, all checked every cycle against a queue-based model.
module tb_vector_instruction_sequencer;

    localparam int DEPTH      = 8;
    localparam int ALU_CYCLES = 2;
    localparam int MEM_CYCLES = 1;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [8:0] in_instr;
    logic       in_ready;
    logic       run;
    logic [1:0] opcode;
    logic [1:0] regAddress;
    logic [4:0] memoryAddress;
    logic       issue_valid;
    logic       retire;
    logic       busy;
    logic [4:0] fifo_count;
    logic [7:0] retired_count;

    int n_checks;
    int n_errors;

    // Reference model: a queue of pending instructions, the instruction being
    // held, and how many of its cycles are still to run (including this one).
    logic [8:0] q[$];
    logic [8:0] cur;
    int         rem;
    bit         active;
    int         retired;

    vector_instruction_sequencer #(
        .DEPTH(DEPTH), .ALU_CYCLES(ALU_CYCLES), .MEM_CYCLES(MEM_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr),
        .in_ready(in_ready), .run(run), .opcode(opcode), .regAddress(regAddress),
        .memoryAddress(memoryAddress), .issue_valid(issue_valid), .retire(retire),
        .busy(busy), .fifo_count(fifo_count), .retired_count(retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int cycles_of(input logic [8:0] instr);
        return instr[8] ? MEM_CYCLES : ALU_CYCLES;
    endfunction

    // Advance the model by one clock edge using the inputs present at the edge.
    task automatic model_step();
        bit ready;
        bit retiring;
        bit can_pop;
        if (rst) begin
            q.delete();
            active  = 1'b0;
            cur     = 9'd0;
            rem     = 0;
            retired = 0;
        end else begin
            ready    = (q.size() < DEPTH);
            retiring = active && (rem == 1);
            can_pop  = run && (q.size() > 0) && (!active || retiring);
            if (retiring) begin
                retired = (retired + 1) % 256;
                active  = 1'b0;
            end else if (active) begin
                rem = rem - 1;
            end
            if (can_pop) begin
                cur    = q.pop_front();
                active = 1'b1;
                rem    = cycles_of(cur);
            end
            if (in_valid && ready) q.push_back(in_instr);
        end
    endtask

    task automatic compare_all();
        chk_eq("opcode",        opcode,        cur[8:7]);
        chk_eq("regAddress",    regAddress,    cur[6:5]);
        chk_eq("memoryAddress", memoryAddress, cur[4:0]);
        chk_eq("issue_valid",   issue_valid,   active);
        chk_eq("retire",        retire,        (active && rem == 1) ? 1 : 0);
        chk_eq("busy",          busy,          (active || q.size() > 0) ? 1 : 0);
        chk_eq("fifo_count",    fifo_count,    q.size());
        chk_eq("in_ready",      in_ready,      (q.size() < DEPTH) ? 1 : 0);
        chk_eq("retired_count", retired_count, retired);
    endtask

    // One clock: edge, model update, then sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; run = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic push(input logic [8:0] instr);
        in_valid = 1'b1; in_instr = instr;
        tick();
        in_valid = 1'b0;
    endtask

    int pushed;
    int retires_seen;

    initial begin
        n_checks = 0; n_errors = 0;
        rst = 1'b1; in_valid = 1'b0; in_instr = 9'd0; run = 1'b0;
        cur = 9'd0; rem = 0; active = 1'b0; retired = 0;
        #2;
        tick();
        tick();
        rst = 1'b0;
        chk_eq("reset_ready", in_ready, 1);
        chk_eq("reset_busy",  busy,     0);

        // Single LOAD
        run = 1'b1;
        push(9'b10_01_00101);
        tick();
        chk_eq("load_op",     opcode,        2);
        chk_eq("load_reg",    regAddress,    1);
        chk_eq("load_mem",    memoryAddress, 5);
        chk_eq("load_valid",  issue_valid,   1);
        chk_eq("load_retire", retire,        1);
        tick();
        chk_eq("load_retired", retired_count, 1);
        chk_eq("load_busy",    busy,          0);

        // ADD r0 then MUL r1 back-to-back
        do_reset();
        push(9'b00_00_00011);
        push(9'b01_01_00111);
        run = 1'b1;
        retires_seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (retire) retires_seen++;
        end
        chk_eq("addmul_retires", retires_seen,  2);
        chk_eq("addmul_count",   retired_count, 2);

        // Fill with run low
        do_reset();
        for (int i = 0; i < 9; i++) begin
            push(9'($urandom));
            if (i == 7) chk_eq("fill_ready_low", in_ready, 0);
        end
        chk_eq("fill_count", fifo_count, 8);
        run = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk_eq("fill_retired", retired_count, 8);

        // run dropped mid-MUL
        do_reset();
        push(9'b01_10_01010);
        push(9'b00_01_00001);
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        tick();
        chk_eq("runoff_valid", issue_valid, 0);
        chk_eq("runoff_count", fifo_count,  1);

        // Reset during ADD cycle 1 with 3 queued
        do_reset();
        push(9'b00_11_11111);
        for (int i = 0; i < 3; i++) push(9'($urandom));
        run = 1'b1;
        tick();
        rst = 1'b1; in_valid = 1'b1; in_instr = 9'b11_11_11111;
        tick();
        rst = 1'b0; in_valid = 1'b0; run = 1'b0;
        chk_eq("rst_count",  fifo_count,  0);
        chk_eq("rst_valid",  issue_valid, 0);
        chk_eq("rst_retire", retire,      0);
        chk_eq("rst_op",     opcode,      0);

        // 256 STOREs streamed
        run = 1'b1;
        pushed = 0; retires_seen = 0;
        for (int i = 0; i < 1000 && pushed < 256; i++) begin
            in_valid = 1'b1;
            in_instr = {2'b11, 2'(pushed), 5'(pushed)};
            if (in_ready) pushed++;
            tick();
            if (retire) retires_seen++;
        end
        in_valid = 1'b0;
        chk_eq("stream_pushed", pushed, 256);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (retire) retires_seen++;
        end
        chk_eq("stream_retires", retires_seen,  256);
        chk_eq("stream_wrap",    retired_count, 0);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 199) == 0);
            in_valid = ($urandom_range(0, 99) < 55);
            in_instr = 9'($urandom);
            run      = ($urandom_range(0, 99) < 70);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
